spi_master_ctrl: RTL
====================

Name: spi_master_ctrl

Overview:
SPI mode-0 master controller (CPOL=0, CPHA=0) that sequences multi-byte transfers to an SPI slave on the sclk/cs/mosi/miso bus. Runs entirely in the system clock domain and generates sclk by integer division. Accepts a transaction request (start + byte count), pulls transmit bytes through a valid/ready handshake, and returns each received byte with a one-cycle valid strobe. MSB first on both mosi and miso.

Parameters:
CLK_DIV, 4, system clocks per sclk half-period (legal range >=1; 1 gives sclk = clk/2)
DATA_W, 8, bits per SPI byte (fixed at 8 for this release)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  transaction request; sampled only when busy=0
len  input  4  byte count minus one (0 -> 1 byte, 15 -> 16 bytes); latched with start
tx_data  input  8  next byte to transmit
tx_valid  input  1  tx_data valid
tx_ready  output  1  controller accepts tx_data this cycle
rx_data  output  8  last received byte; held until next byte completes
rx_valid  output  1  one-cycle pulse, rx_data updated
busy  output  1  transaction in progress
done  output  1  one-cycle pulse at end of transaction
sclk  output  1  SPI clock, idles low
cs  output  1  chip select, active low
mosi  output  1  serial data to slave
miso  input  1  serial data from slave

Behaviour:
- Reset values: sclk=0, cs=1, mosi=0, busy=0, done=0, tx_ready=0, rx_valid=0, rx_data=0; internal counters cleared; FSM to IDLE.
- States: IDLE, SETUP, LOAD, SHIFT, HOLD, GAP.
- IDLE: start=1 -> latch len, cs=0 and busy=1 on next cycle, go SETUP. start while busy=1 ignored (not queued).
- SETUP: hold cs=0, sclk=0 for CLK_DIV cycles -> LOAD.
- LOAD: tx_ready=1. On tx_valid&&tx_ready, latch tx_data into shift register, mosi=tx_data[7] next cycle, go SHIFT. If tx_valid=0, wait indefinitely with cs=0, sclk=0, mosi unchanged. tx_ready is 0 in every other state.
- SHIFT, per bit (8 bits): low phase CLK_DIV cycles (mosi stable) -> the clk edge that drives sclk 1 also samples miso into the rx shift register (LSB-in, left shift); high phase CLK_DIV cycles -> clk edge that drives sclk 0 presents next mosi bit. After bit 7's high phase: sclk=0, rx_data=assembled byte, rx_valid=1 for one cycle (same edge); byte counter decrements.
- After a byte: bytes remaining -> LOAD; last byte -> HOLD.
- HOLD: cs=0, sclk=0 for CLK_DIV cycles, then cs=1 -> GAP.
- GAP: cs=1 for CLK_DIV cycles, then done=1 for one cycle, busy=0, -> IDLE. New start is accepted on the cycle done is high or later.
- Timing with tx_valid always high: done pulses exactly 3*CLK_DIV + N*(16*CLK_DIV+1) + 1 cycles after the cycle start is sampled (N = len+1).
- mosi driven 0 in IDLE/GAP; holds last bit in HOLD.
- Byte counter 4 bits with +1 offset; no wrap: len=15 produces exactly 16 bytes.
- rst mid-transaction (any state): next edge forces reset values; partial byte discarded, no rx_valid, no done.
- sclk never glitches: each phase is a full CLK_DIV cycles, including the first bit after a LOAD stall.

Test Plan:
- CLK_DIV=2, len=0, tx_data=0xA5, slave model returns 0x3C -> mosi bits 1,0,1,0,0,1,0,1 on 8 rising sclk edges; rx_data=0x3C with one rx_valid; done 3*2+1*33+1=40 cycles after start; cs low for whole frame.
- CLK_DIV=1, len=2, tx bytes 0x11,0x22,0x33, slave returns 0xF0,0x0F,0x81 -> three rx_valid pulses with those values, cs continuous low, 24 sclk rising edges total, done at 3+3*17+1=55 cycles.
- len=1, tx_valid withheld 20 cycles before byte 2 -> sclk stays 0 and cs stays 0 during stall; no extra sclk edges; both bytes correct.
- start asserted while busy=1 with len=5 -> ignored; active transaction byte count unchanged; exactly one done.
- rst asserted during bit 4 of byte 1 -> next cycle cs=1, sclk=0, busy=0; no rx_valid/done; a following start runs a clean transaction.
- len=15, CLK_DIV=1, incrementing tx 0x00..0x0F, loopback mosi->miso -> 16 rx_valid pulses returning 0x00..0x0F, then one done.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode-0 (CPOL=0, CPHA=0) master sequencer.
// Runs one multi-byte frame per request. sclk is derived from clk by
// counting CLK_DIV system cycles per half-period. Data is MSB first in
// both directions. Every bus-facing output comes straight from a flop.
module spi_master_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        len,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              cs,
    output logic              mosi,
    input  logic              miso
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_LOAD  = 3'd2,
        S_SHIFT = 3'd3,
        S_HOLD  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;       // cycles spent in the current phase
    logic [BIT_W-1:0]   r_bit;       // bit index inside the current byte
    logic [3:0]         r_left;      // bytes remaining after the current one
    logic [DATA_W-1:0]  r_tx_sh;
    logic [DATA_W-1:0]  r_rx_sh;
    logic [DATA_W-1:0]  r_rx_data;
    logic               r_rx_valid;
    logic               r_tx_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_sclk;
    logic               r_cs;
    logic               r_mosi;

    logic               w_phase_end;
    logic               w_last_bit;

    assign w_phase_end = (r_cnt == CNT_W'(CLK_DIV - 1));
    assign w_last_bit  = (r_bit == BIT_W'(DATA_W - 1));

    // Frame sequencer: state, phase timing, shift registers and all outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_left     <= 4'd0;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sclk     <= 1'b0;
            r_cs       <= 1'b1;
            r_mosi     <= 1'b0;
        end else begin
            // Strobes last exactly one cycle unless re-asserted below.
            r_done     <= 1'b0;
            r_rx_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_mosi <= 1'b0;
                    if (start) begin
                        r_left  <= len;
                        r_cs    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_SETUP;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SETUP: begin
                    if (w_phase_end) begin
                        r_cnt      <= '0;
                        r_tx_ready <= 1'b1;
                        r_state    <= S_LOAD;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_LOAD: begin
                    // Stall here with sclk low for as long as no byte is offered.
                    if (tx_valid && r_tx_ready) begin
                        r_tx_sh    <= tx_data;
                        r_mosi     <= tx_data[DATA_W-1];
                        r_tx_ready <= 1'b0;
                        r_bit      <= '0;
                        r_cnt      <= '0;
                        r_state    <= S_SHIFT;
                    end else begin
                        r_state <= S_LOAD;
                    end
                end
                S_SHIFT: begin
                    if (!w_phase_end) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else if (!r_sclk) begin
                        // Rising sclk: sample miso into the receive shifter.
                        r_cnt   <= '0;
                        r_sclk  <= 1'b1;
                        r_rx_sh <= {r_rx_sh[DATA_W-2:0], miso};
                    end else begin
                        // Falling sclk: either finish the byte or present the next bit.
                        r_cnt  <= '0;
                        r_sclk <= 1'b0;
                        if (w_last_bit) begin
                            r_rx_data  <= r_rx_sh;
                            r_rx_valid <= 1'b1;
                            if (r_left == 4'd0) begin
                                r_state <= S_HOLD;
                            end else begin
                                r_left     <= r_left - 4'd1;
                                r_tx_ready <= 1'b1;
                                r_state    <= S_LOAD;
                            end
                        end else begin
                            r_bit   <= r_bit + BIT_W'(1);
                            r_tx_sh <= {r_tx_sh[DATA_W-2:0], 1'b0};
                            r_mosi  <= r_tx_sh[DATA_W-2];
                        end
                    end
                end
                S_HOLD: begin
                    if (w_phase_end) begin
                        r_cnt   <= '0;
                        r_cs    <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_state <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (w_phase_end) begin
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_cnt      <= '0;
                    r_tx_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_sclk     <= 1'b0;
                    r_cs       <= 1'b1;
                    r_mosi     <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready = r_tx_ready;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = r_busy;
    assign done     = r_done;
    assign sclk     = r_sclk;
    assign cs       = r_cs;
    assign mosi     = r_mosi;

endmodule
